// File: rtl/dsp19x2_cfg_pkg.sv
// Shared constants and FSM state type for the DSP19X2 MODE_BITS readback unpacker.
// Optional feature macro used across this slice: DSP19X2_CFG_PARITY_EN.
package dsp19x2_cfg_pkg;

  localparam int unsigned MODE_BITS_W = 85;
  localparam int unsigned COEFF_W     = 10;
  localparam int unsigned MODE_W      = 4;

  // Field LSB positions inside MODE_BITS[84:0]
  localparam int unsigned C1_0_LSB  = 75;
  localparam int unsigned C2_0_LSB  = 65;
  localparam int unsigned C1_1_LSB  = 55;
  localparam int unsigned C2_1_LSB  = 45;
  localparam int unsigned C1_2_LSB  = 35;
  localparam int unsigned C2_2_LSB  = 25;
  localparam int unsigned C1_3_LSB  = 15;
  localparam int unsigned C2_3_LSB  = 5;
  localparam int unsigned MODE_LSB  = 1;
  localparam int unsigned SPLIT_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    CHECK,
    HOLD
  } state_t;

endpackage

// File: rtl/dsp19x2_cfg_shifter.sv
// Beat shift register, beat counter and frame-length classification for the unpacker.
// DSP19X2_CFG_PARITY_EN adds per-beat even-parity accumulation across the frame.
module dsp19x2_cfg_shifter
  import dsp19x2_cfg_pkg::*;
#(
  parameter int unsigned CFG_W = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   beat,
  input  logic [CFG_W-1:0]       data,
  input  logic                   last,
`ifdef DSP19X2_CFG_PARITY_EN
  input  logic                   par,
  output logic                   par_bad,
`endif
  output logic [MODE_BITS_W-1:0] image,
  output logic                   is_final,
  output logic                   short_err,
  output logic                   long_err
);

  localparam int unsigned BEATS = MODE_BITS_W / CFG_W;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  logic [CNT_W-1:0] cnt;

  assign is_final  = (cnt == CNT_W'(BEATS - 1));
  assign short_err = last && !is_final;
  assign long_err  = is_final && !last;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      image <= '0;
      cnt   <= '0;
`ifdef DSP19X2_CFG_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else if (beat) begin
      image <= MODE_BITS_W'({image, data});
      // Counter rewinds on any frame-terminating beat, good or bad
      cnt   <= (last || is_final) ? '0 : cnt + CNT_W'(1);
`ifdef DSP19X2_CFG_PARITY_EN
      par_bad <= ((cnt == '0) ? 1'b0 : par_bad) | ((^data) != par);
`endif
    end
  end

endmodule

// File: rtl/dsp19x2_mode_bits_unpacker.sv
// Unpacks a serial RS_DSP_MULTADD MODE_BITS frame into the DSP19X2 coefficient/mode view.
// Define DSP19X2_CFG_PARITY_EN to add the CFG_PAR even-parity input and bad-frame rejection.
module dsp19x2_mode_bits_unpacker
  import dsp19x2_cfg_pkg::*;
#(
  parameter int unsigned CFG_W = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [CFG_W-1:0]   CFG_DATA,
  input  logic               CFG_VALID,
  input  logic               CFG_LAST,
`ifdef DSP19X2_CFG_PARITY_EN
  input  logic               CFG_PAR,
`endif
  output logic               CFG_READY,
  output logic [COEFF_W-1:0] COEFF1_0,
  output logic [COEFF_W-1:0] COEFF1_1,
  output logic [COEFF_W-1:0] COEFF1_2,
  output logic [COEFF_W-1:0] COEFF1_3,
  output logic [COEFF_W-1:0] COEFF2_0,
  output logic [COEFF_W-1:0] COEFF2_1,
  output logic [COEFF_W-1:0] COEFF2_2,
  output logic [COEFF_W-1:0] COEFF2_3,
  output logic [MODE_W-1:0]  MODE,
  output logic               SPLIT,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               ERR
);

  state_t                 state;
  logic                   beat;
  logic [MODE_BITS_W-1:0] image;
  logic                   is_final;
  logic                   short_err;
  logic                   long_err;
`ifdef DSP19X2_CFG_PARITY_EN
  logic                   par_bad;
`endif

  assign beat = CFG_VALID && CFG_READY && ((state == IDLE) || (state == LOAD));

  dsp19x2_cfg_shifter #(.CFG_W(CFG_W)) u_shifter (
    .CLK       (CLK),
    .RESET     (RESET),
    .beat      (beat),
    .data      (CFG_DATA),
    .last      (CFG_LAST),
`ifdef DSP19X2_CFG_PARITY_EN
    .par       (CFG_PAR),
    .par_bad   (par_bad),
`endif
    .image     (image),
    .is_final  (is_final),
    .short_err (short_err),
    .long_err  (long_err)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      CFG_READY <= 1'b0;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
      COEFF1_0  <= '0;
      COEFF1_1  <= '0;
      COEFF1_2  <= '0;
      COEFF1_3  <= '0;
      COEFF2_0  <= '0;
      COEFF2_1  <= '0;
      COEFF2_2  <= '0;
      COEFF2_3  <= '0;
      MODE      <= '0;
      SPLIT     <= 1'b0;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        // A LAST on the very first beat of a multi-beat frame is treated as short
        IDLE, LOAD: begin
          CFG_READY <= 1'b1;
          if (beat) begin
            if (short_err) begin
              ERR   <= 1'b1;
              state <= IDLE;
            end else if (long_err) begin
              ERR   <= 1'b1;
              state <= DRAIN;
            end else if (CFG_LAST && is_final) begin
              CFG_READY <= 1'b0;
              state     <= CHECK;
            end else begin
              state <= LOAD;
            end
          end
        end
        DRAIN: begin
          CFG_READY <= 1'b1;
          if (CFG_VALID && CFG_READY && CFG_LAST) state <= IDLE;
        end
        CHECK: begin
`ifdef DSP19X2_CFG_PARITY_EN
          if (par_bad) begin
            ERR       <= 1'b1;
            CFG_READY <= 1'b1;
            state     <= IDLE;
          end else
`endif
          begin
            COEFF1_0  <= image[C1_0_LSB +: COEFF_W];
            COEFF2_0  <= image[C2_0_LSB +: COEFF_W];
            COEFF1_1  <= image[C1_1_LSB +: COEFF_W];
            COEFF2_1  <= image[C2_1_LSB +: COEFF_W];
            COEFF1_2  <= image[C1_2_LSB +: COEFF_W];
            COEFF2_2  <= image[C2_2_LSB +: COEFF_W];
            COEFF1_3  <= image[C1_3_LSB +: COEFF_W];
            COEFF2_3  <= image[C2_3_LSB +: COEFF_W];
            MODE      <= image[MODE_LSB +: MODE_W];
            SPLIT     <= image[SPLIT_BIT];
            OUT_VALID <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            CFG_READY <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          CFG_READY <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp19x2_mode_bits_unpacker.sv
// Directed bench for dsp19x2_mode_bits_unpacker: one instance at CFG_W=1, one at CFG_W=17.
// Parity cases are compiled in when DSP19X2_CFG_PARITY_EN is defined.
module tb_dsp19x2_mode_bits_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        d1 = 1'b0, v1 = 1'b0, l1 = 1'b0, or1 = 1'b0;
  logic        r1, ov1, e1, s1;
  logic [3:0]  m1;
  logic [9:0]  a1 [4];
  logic [9:0]  b1 [4];

  logic [16:0] d17 = '0;
  logic        v17 = 1'b0, l17 = 1'b0, or17 = 1'b0;
  logic        r17, ov17, e17, s17;
  logic [3:0]  m17;
  logic [9:0]  a17 [4];
  logic [9:0]  b17 [4];
`ifdef DSP19X2_CFG_PARITY_EN
  logic        p1 = 1'b0, p17 = 1'b0;
`endif

  dsp19x2_mode_bits_unpacker #(.CFG_W(1)) u_w1 (
    .CLK(clk), .RESET(rst_n), .CFG_DATA(d1), .CFG_VALID(v1), .CFG_LAST(l1),
`ifdef DSP19X2_CFG_PARITY_EN
    .CFG_PAR(p1),
`endif
    .CFG_READY(r1),
    .COEFF1_0(a1[0]), .COEFF1_1(a1[1]), .COEFF1_2(a1[2]), .COEFF1_3(a1[3]),
    .COEFF2_0(b1[0]), .COEFF2_1(b1[1]), .COEFF2_2(b1[2]), .COEFF2_3(b1[3]),
    .MODE(m1), .SPLIT(s1), .OUT_VALID(ov1), .OUT_READY(or1), .ERR(e1)
  );

  dsp19x2_mode_bits_unpacker #(.CFG_W(17)) u_w17 (
    .CLK(clk), .RESET(rst_n), .CFG_DATA(d17), .CFG_VALID(v17), .CFG_LAST(l17),
`ifdef DSP19X2_CFG_PARITY_EN
    .CFG_PAR(p17),
`endif
    .CFG_READY(r17),
    .COEFF1_0(a17[0]), .COEFF1_1(a17[1]), .COEFF1_2(a17[2]), .COEFF1_3(a17[3]),
    .COEFF2_0(b17[0]), .COEFF2_1(b17[1]), .COEFF2_2(b17[2]), .COEFF2_3(b17[3]),
    .MODE(m17), .SPLIT(s17), .OUT_VALID(ov17), .OUT_READY(or17), .ERR(e17)
  );

  function automatic logic [84:0] mk(input logic [9:0] c10, c20, c11, c21, c12, c22, c13, c23,
                                     input logic [3:0] m, input logic s);
    return {c10, c20, c11, c21, c12, c22, c13, c23, m, s};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input bit w17, input logic [84:0] img, input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_c1_%0d", tag, i), w17 ? a17[i] : a1[i], img[84-20*i -: 10]);
      chk($sformatf("%s_c2_%0d", tag, i), w17 ? b17[i] : b1[i], img[74-20*i -: 10]);
    end
    chk({tag, "_mode"},  w17 ? m17 : m1, img[4:1]);
    chk({tag, "_split"}, w17 ? s17 : s1, img[0]);
  endtask

  // Sends nbeats beats; reports ERR pulses (ebeat=nbeats means seen after the frame)
  // and OUT_VALID one and two cycles after the final handshake.
  task automatic send(input bit w17, input logic [84:0] img, input int nbeats, input int last_at,
                      input int bad_beat, input bit gap,
                      output int ecnt, output int ebeat, output logic ov_a, output logic ov_b);
    int n;
    ecnt = 0; ebeat = -1; ov_a = 1'b0; ov_b = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gap && i > 0) begin
        if (w17) v17 = 1'b0; else v1 = 1'b0;
        repeat (2) @(negedge clk);
      end
      if (w17) begin
        if (i < 5) d17 = img[84-17*i -: 17]; else d17 = img[16:0];
        l17 = (i == last_at);
        v17 = 1'b1;
`ifdef DSP19X2_CFG_PARITY_EN
        p17 = (^d17) ^ (i == bad_beat);
`endif
      end else begin
        d1 = img[84-i];
        l1 = (i == last_at);
        v1 = 1'b1;
`ifdef DSP19X2_CFG_PARITY_EN
        p1 = d1 ^ (i == bad_beat);
`endif
      end
      n = 0;
      while (!(w17 ? r17 : r1) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $error("FAIL ready_timeout: beat %0d observed CFG_READY 0 expected 1", i);
      end
      @(negedge clk);
      if (w17 ? e17 : e1) begin ecnt++; ebeat = i; end
      ov_a = w17 ? ov17 : ov1;
    end
    if (w17) begin v17 = 1'b0; l17 = 1'b0; end else begin v1 = 1'b0; l1 = 1'b0; end
    @(negedge clk);
    if (w17 ? e17 : e1) begin ecnt++; ebeat = nbeats; end
    ov_b = w17 ? ov17 : ov1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [84:0] ia, ib, ic, id, ie;
    int          ec, eb;
    logic        ova, ovb;

    ia = mk(10'h3A5, 10'h001, 10'h2FF, 10'h100, 10'h0AA, 10'h355, 10'h3FF, 10'h15A, 4'hA, 1'b1);
    ib = mk(10'h123, 10'h0F0, 10'h3C3, 10'h081, 10'h200, 10'h1FE, 10'h00F, 10'h2A9, 4'h5, 1'b0);
    ic = mk(10'h111, 10'h222, 10'h333, 10'h044, 10'h155, 10'h266, 10'h377, 10'h088, 4'hC, 1'b1);
    id = mk(10'h3FE, 10'h001, 10'h2AA, 10'h155, 10'h0C3, 10'h33C, 10'h181, 10'h27E, 4'h3, 1'b0);
    ie = mk(10'h0DE, 10'h2AD, 10'h1BE, 10'h3EF, 10'h0CA, 10'h2FE, 10'h1BA, 10'h0BE, 4'h9, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready1", r1, 1'b0);
    chk("rst_ready17", r17, 1'b0);
    chk("rst_ov1", ov1, 1'b0);
    chk("rst_err1", e1, 1'b0);
    chk_fields(1'b0, 85'h0, "rst_w1");
    chk_fields(1'b1, 85'h0, "rst_w17");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready1", r1, 1'b1);
    chk("idle_ready17", r17, 1'b1);

    // CFG_W=1 full frame; OUT_READY pulsed while idle must be ignored
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    send(1'b0, ia, 85, 84, -1, 1'b0, ec, eb, ova, ovb);
    chk("w1_err", ec, 0);
    chk("w1_ov_plus1", ova, 1'b0);
    chk("w1_ov_plus2", ovb, 1'b1);
    chk("w1_hold_ready", r1, 1'b0);
    chk_fields(1'b0, ia, "w1_a");
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    chk("w1_ov_drop", ov1, 1'b0);
    chk("w1_ready_back", r1, 1'b1);
    chk_fields(1'b0, ia, "w1_a_kept");

    // CFG_W=17 frame with CFG_VALID stalls, then a 10-cycle OUT_READY hold-off
    send(1'b1, ib, 5, 4, -1, 1'b1, ec, eb, ova, ovb);
    chk("w17_err", ec, 0);
    chk("w17_ov_plus1", ova, 1'b0);
    chk("w17_ov_plus2", ovb, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold_ov_%0d", k), ov17, 1'b1);
      chk($sformatf("hold_ready_%0d", k), r17, 1'b0);
      chk($sformatf("hold_c1_0_%0d", k), a17[0], 10'h123);
      chk($sformatf("hold_c2_3_%0d", k), b17[3], 10'h2A9);
    end
    chk_fields(1'b1, ib, "w17_b");
    or17 = 1'b1;
    @(negedge clk);
    chk("w17_ov_drop", ov17, 1'b0);
    chk("w17_ready_back", r17, 1'b1);

    // Short frame: LAST on beat 3 of 5
    send(1'b1, ic, 3, 2, -1, 1'b0, ec, eb, ova, ovb);
    or17 = 1'b0;
    chk("short_err_cnt", ec, 1);
    chk("short_err_beat", eb, 2);
    chk("short_ov_a", ova, 1'b0);
    chk("short_ov_b", ovb, 1'b0);
    chk("short_ready", r17, 1'b1);
    chk_fields(1'b1, ib, "short_kept");

    // Long frame: 7 beats, single ERR on beat 5, rest drained
    send(1'b1, ic, 7, 6, -1, 1'b0, ec, eb, ova, ovb);
    chk("long_err_cnt", ec, 1);
    chk("long_err_beat", eb, 4);
    chk("long_ov", ovb, 1'b0);
    chk("long_ready", r17, 1'b1);
    chk_fields(1'b1, ib, "long_kept");
    send(1'b1, ic, 5, 4, -1, 1'b0, ec, eb, ova, ovb);
    chk("after_long_err", ec, 0);
    chk("after_long_ov", ovb, 1'b1);
    chk_fields(1'b1, ic, "after_long");
    or17 = 1'b1;
    @(negedge clk);
    or17 = 1'b0;

`ifdef DSP19X2_CFG_PARITY_EN
    // Bad parity on beat 2 rejects the frame at CHECK
    send(1'b1, id, 5, 4, 1, 1'b0, ec, eb, ova, ovb);
    chk("par_err_cnt", ec, 1);
    chk("par_err_beat", eb, 5);
    chk("par_ov", ovb, 1'b0);
    chk_fields(1'b1, ic, "par_kept");
    send(1'b1, id, 5, 4, -1, 1'b0, ec, eb, ova, ovb);
    chk("par_good_err", ec, 0);
    chk("par_good_ov", ovb, 1'b1);
    chk_fields(1'b1, id, "par_good");
    or17 = 1'b1;
    @(negedge clk);
    or17 = 1'b0;
`endif

    // Reset after 40 beats of a CFG_W=1 frame, then a fresh frame
    send(1'b0, ie, 40, -1, -1, 1'b0, ec, eb, ova, ovb);
    chk("mid_no_err", ec, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", r1, 1'b0);
    chk("mid_rst_ov", ov1, 1'b0);
    chk_fields(1'b0, 85'h0, "mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, ie, 85, 84, -1, 1'b0, ec, eb, ova, ovb);
    chk("fresh_err", ec, 0);
    chk("fresh_ov", ovb, 1'b1);
    chk_fields(1'b0, ie, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
